// File: rtl/instr_encoder.sv
`timescale 1ns/1ps
// RV32I assembler back end: turns an operation request into a program-memory write.
// Latency: one cycle from request acceptance to instr/pmem_addr/out_valid.
// Backpressure: one output register; in_ready = !out_valid || out_ready; rejects are consumed.
module instr_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic [31:0] pmem_addr,
  input  logic        load_addr,
  input  logic [31:0] load_val,
  output logic        err_pulse,
  output logic        err_sticky,
  input  logic        err_clr
);

  // Operation codes presented on the op port
  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_SLL   = 6'd2;
  localparam logic [5:0] OP_SLT   = 6'd3;
  localparam logic [5:0] OP_SLTU  = 6'd4;
  localparam logic [5:0] OP_XOR   = 6'd5;
  localparam logic [5:0] OP_SRL   = 6'd6;
  localparam logic [5:0] OP_SRA   = 6'd7;
  localparam logic [5:0] OP_OR    = 6'd8;
  localparam logic [5:0] OP_AND   = 6'd9;
  localparam logic [5:0] OP_ADDI  = 6'd10;
  localparam logic [5:0] OP_SLTI  = 6'd11;
  localparam logic [5:0] OP_SLTIU = 6'd12;
  localparam logic [5:0] OP_XORI  = 6'd13;
  localparam logic [5:0] OP_ORI   = 6'd14;
  localparam logic [5:0] OP_ANDI  = 6'd15;
  localparam logic [5:0] OP_SLLI  = 6'd16;
  localparam logic [5:0] OP_SRLI  = 6'd17;
  localparam logic [5:0] OP_SRAI  = 6'd18;
  localparam logic [5:0] OP_LB    = 6'd19;
  localparam logic [5:0] OP_LH    = 6'd20;
  localparam logic [5:0] OP_LW    = 6'd21;
  localparam logic [5:0] OP_LBU   = 6'd22;
  localparam logic [5:0] OP_LHU   = 6'd23;
  localparam logic [5:0] OP_SB    = 6'd24;
  localparam logic [5:0] OP_SH    = 6'd25;
  localparam logic [5:0] OP_SW    = 6'd26;
  localparam logic [5:0] OP_BEQ   = 6'd27;
  localparam logic [5:0] OP_BNE   = 6'd28;
  localparam logic [5:0] OP_BLT   = 6'd29;
  localparam logic [5:0] OP_BGE   = 6'd30;
  localparam logic [5:0] OP_BLTU  = 6'd31;
  localparam logic [5:0] OP_BGEU  = 6'd32;
  localparam logic [5:0] OP_JAL   = 6'd33;
  localparam logic [5:0] OP_JALR  = 6'd34;
  localparam logic [5:0] OP_LUI   = 6'd35;
  localparam logic [5:0] OP_AUIPC = 6'd36;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  // Encoding format; FMT_SH is I-type with a 5-bit shift amount and funct7
  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_J, FMT_U, FMT_BAD
  } fmt_t;

  fmt_t               fmt;
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic               imm_ok;
  logic [31:0]        word;
  logic signed [31:0] imm_s;

  logic        accept;
  logic        legal;
  logic        out_hs;
  logic [31:0] addr_cnt;

  assign imm_s = imm;

  // Decode the operation into format, major opcode and function fields
  always_comb begin
    fmt    = FMT_BAD;
    opcode = 7'd0;
    funct3 = 3'd0;
    funct7 = 7'd0;
    case (op)
      OP_ADD:   begin fmt = FMT_R;  opcode = OPC_OP;     funct3 = 3'd0; end
      OP_SUB:   begin fmt = FMT_R;  opcode = OPC_OP;     funct3 = 3'd0; funct7 = F7_ALT; end
      OP_SLL:   begin fmt = FMT_R;  opcode = OPC_OP;     funct3 = 3'd1; end
      OP_SLT:   begin fmt = FMT_R;  opcode = OPC_OP;     funct3 = 3'd2; end
      OP_SLTU:  begin fmt = FMT_R;  opcode = OPC_OP;     funct3 = 3'd3; end
      OP_XOR:   begin fmt = FMT_R;  opcode = OPC_OP;     funct3 = 3'd4; end
      OP_SRL:   begin fmt = FMT_R;  opcode = OPC_OP;     funct3 = 3'd5; end
      OP_SRA:   begin fmt = FMT_R;  opcode = OPC_OP;     funct3 = 3'd5; funct7 = F7_ALT; end
      OP_OR:    begin fmt = FMT_R;  opcode = OPC_OP;     funct3 = 3'd6; end
      OP_AND:   begin fmt = FMT_R;  opcode = OPC_OP;     funct3 = 3'd7; end
      OP_ADDI:  begin fmt = FMT_I;  opcode = OPC_OPIMM;  funct3 = 3'd0; end
      OP_SLTI:  begin fmt = FMT_I;  opcode = OPC_OPIMM;  funct3 = 3'd2; end
      OP_SLTIU: begin fmt = FMT_I;  opcode = OPC_OPIMM;  funct3 = 3'd3; end
      OP_XORI:  begin fmt = FMT_I;  opcode = OPC_OPIMM;  funct3 = 3'd4; end
      OP_ORI:   begin fmt = FMT_I;  opcode = OPC_OPIMM;  funct3 = 3'd6; end
      OP_ANDI:  begin fmt = FMT_I;  opcode = OPC_OPIMM;  funct3 = 3'd7; end
      OP_SLLI:  begin fmt = FMT_SH; opcode = OPC_OPIMM;  funct3 = 3'd1; end
      OP_SRLI:  begin fmt = FMT_SH; opcode = OPC_OPIMM;  funct3 = 3'd5; end
      OP_SRAI:  begin fmt = FMT_SH; opcode = OPC_OPIMM;  funct3 = 3'd5; funct7 = F7_ALT; end
      OP_LB:    begin fmt = FMT_I;  opcode = OPC_LOAD;   funct3 = 3'd0; end
      OP_LH:    begin fmt = FMT_I;  opcode = OPC_LOAD;   funct3 = 3'd1; end
      OP_LW:    begin fmt = FMT_I;  opcode = OPC_LOAD;   funct3 = 3'd2; end
      OP_LBU:   begin fmt = FMT_I;  opcode = OPC_LOAD;   funct3 = 3'd4; end
      OP_LHU:   begin fmt = FMT_I;  opcode = OPC_LOAD;   funct3 = 3'd5; end
      OP_SB:    begin fmt = FMT_S;  opcode = OPC_STORE;  funct3 = 3'd0; end
      OP_SH:    begin fmt = FMT_S;  opcode = OPC_STORE;  funct3 = 3'd1; end
      OP_SW:    begin fmt = FMT_S;  opcode = OPC_STORE;  funct3 = 3'd2; end
      OP_BEQ:   begin fmt = FMT_B;  opcode = OPC_BRANCH; funct3 = 3'd0; end
      OP_BNE:   begin fmt = FMT_B;  opcode = OPC_BRANCH; funct3 = 3'd1; end
      OP_BLT:   begin fmt = FMT_B;  opcode = OPC_BRANCH; funct3 = 3'd4; end
      OP_BGE:   begin fmt = FMT_B;  opcode = OPC_BRANCH; funct3 = 3'd5; end
      OP_BLTU:  begin fmt = FMT_B;  opcode = OPC_BRANCH; funct3 = 3'd6; end
      OP_BGEU:  begin fmt = FMT_B;  opcode = OPC_BRANCH; funct3 = 3'd7; end
      OP_JAL:   begin fmt = FMT_J;  opcode = OPC_JAL;    end
      OP_JALR:  begin fmt = FMT_I;  opcode = OPC_JALR;   funct3 = 3'd0; end
      OP_LUI:   begin fmt = FMT_U;  opcode = OPC_LUI;    end
      OP_AUIPC: begin fmt = FMT_U;  opcode = OPC_AUIPC;  end
      default:  begin fmt = FMT_BAD; end
    endcase
  end

  // Check that the immediate fits the field of the selected format
  always_comb begin
    imm_ok = 1'b0;
    case (fmt)
      FMT_R:   imm_ok = 1'b1;
      FMT_I,
      FMT_S:   imm_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
      FMT_SH:  imm_ok = (imm[31:5] == 27'd0);
      FMT_B:   imm_ok = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm[0];
      FMT_J:   imm_ok = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm[0];
      FMT_U:   imm_ok = (imm[11:0] == 12'd0);
      default: imm_ok = 1'b0;
    endcase
  end

  // Pack fields into the 32-bit instruction word for the selected format
  always_comb begin
    word = 32'd0;
    case (fmt)
      FMT_R:   word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_SH:  word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
      FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      FMT_U:   word = {imm[31:12], rd, opcode};
      default: word = 32'd0;
    endcase
  end

  // A rejected request is still consumed, so acceptance ignores legality
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign legal     = (fmt != FMT_BAD) && imm_ok;
  assign out_hs    = out_valid && out_ready;
  assign pmem_addr = addr_cnt;

  // Output register: load on legal acceptance, drop after handshake, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      instr     <= 32'd0;
    end else if (accept && legal) begin
      out_valid <= 1'b1;
      instr     <= word;
    end else if (out_hs) begin
      out_valid <= 1'b0;
    end
  end

  // Address counter: an explicit load beats the post-handshake increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt <= 32'd0;
    end else if (load_addr) begin
      addr_cnt <= load_val & 32'hFFFF_FFFC;
    end else if (out_hs) begin
      addr_cnt <= addr_cnt + 32'd4;
    end
  end

  // Reject strobe and sticky flag; a new reject outranks a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      err_pulse  <= accept && !legal;
      err_sticky <= (accept && !legal) || (err_sticky && !err_clr);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
`timescale 1ns/1ps
// Self-checking bench for instr_encoder: scoreboard of expected words plus directed vectors.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [31:0] pmem_addr;
  logic        load_addr;
  logic [31:0] load_val;
  logic        err_pulse;
  logic        err_sticky;
  logic        err_clr;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .pmem_addr(pmem_addr),
    .load_addr(load_addr), .load_val(load_val),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .err_clr(err_clr)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoder: returns {reject, word}
  function automatic logic [32:0] model(input int o, input logic [4:0] d, input logic [4:0] s1,
                                        input logic [4:0] s2, input logic [31:0] im);
    logic signed [31:0] v;
    logic [31:0] w;
    logic        ok;
    logic [2:0]  f3;
    logic [29:0] r_tab;
    logic [17:0] i_tab;
    logic [14:0] l_tab;
    logic [17:0] b_tab;
    v = im; w = 32'd0; ok = 1'b1; f3 = 3'd0;
    r_tab = {3'd7, 3'd6, 3'd5, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    i_tab = {3'd7, 3'd6, 3'd4, 3'd3, 3'd2, 3'd0};
    l_tab = {3'd5, 3'd4, 3'd2, 3'd1, 3'd0};
    b_tab = {3'd7, 3'd6, 3'd5, 3'd4, 3'd1, 3'd0};
    if (o >= 0 && o <= 9) begin
      f3 = r_tab[o*3 +: 3];
      w = {(o == 1 || o == 7) ? 7'h20 : 7'h00, s2, s1, f3, d, 7'h33};
    end else if (o <= 15) begin
      f3 = i_tab[(o-10)*3 +: 3];
      ok = (v >= -2048) && (v <= 2047);
      w = {im[11:0], s1, f3, d, 7'h13};
    end else if (o <= 18) begin
      ok = (im < 32);
      w = {(o == 18) ? 7'h20 : 7'h00, im[4:0], s1, (o == 16) ? 3'd1 : 3'd5, d, 7'h13};
    end else if (o <= 23) begin
      f3 = l_tab[(o-19)*3 +: 3];
      ok = (v >= -2048) && (v <= 2047);
      w = {im[11:0], s1, f3, d, 7'h03};
    end else if (o <= 26) begin
      f3 = 3'(o - 24);
      ok = (v >= -2048) && (v <= 2047);
      w = {im[11:5], s2, s1, f3, im[4:0], 7'h23};
    end else if (o <= 32) begin
      f3 = b_tab[(o-27)*3 +: 3];
      ok = (v >= -4096) && (v <= 4094) && !im[0];
      w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'h63};
    end else if (o == 33) begin
      ok = (v >= -1048576) && (v <= 1048574) && !im[0];
      w = {im[20], im[10:1], im[11], im[19:12], d, 7'h6F};
    end else if (o == 34) begin
      ok = (v >= -2048) && (v <= 2047);
      w = {im[11:0], s1, 3'd0, d, 7'h67};
    end else if (o == 35 || o == 36) begin
      ok = (im[11:0] == 12'd0);
      w = {im[31:12], d, (o == 35) ? 7'h37 : 7'h17};
    end else begin
      ok = 1'b0;
    end
    return {!ok, ok ? w : 32'h0};
  endfunction

  function automatic logic [31:0] pick_imm(input int i);
    case (i)
      0: return 32'd0;          1: return 32'd5;          2: return 32'hFFFF_FFFF;
      3: return 32'd2047;       4: return 32'hFFFF_F800;  5: return 32'd2048;
      6: return 32'hFFFF_F7FF;  7: return 32'd31;         8: return 32'd32;
      9: return 32'hFFFF_F000;  10: return 32'd4094;      11: return 32'd4095;
      12: return 32'd8;         13: return 32'd3;         14: return 32'h1234_5000;
      15: return 32'h000F_FFFE; 16: return 32'hFFF0_0000; 17: return 32'h0010_0000;
      default: return 32'hFFFF_FFFC;
    endcase
  endfunction

  // Scoreboard state, advanced once per cycle at the falling edge
  logic [31:0] sb_q[$];
  logic [31:0] mon_addr;
  logic        exp_pulse;
  logic        exp_sticky;
  logic        req_bad = 1'b0;
  logic [31:0] req_word = 32'd0;
  logic        rand_mode = 1'b0;

  always @(negedge clk) begin
    logic ev, er, rej;
    if (!rst_n) begin
      sb_q.delete();
      mon_addr   = 32'd0;
      exp_pulse  = 1'b0;
      exp_sticky = 1'b0;
    end else begin
      ev = (sb_q.size() != 0);
      er = !ev || out_ready;
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("in_ready", 32'(in_ready), 32'(er));
      chk("err_pulse", 32'(err_pulse), 32'(exp_pulse));
      chk("err_sticky", 32'(err_sticky), 32'(exp_sticky));
      if (ev && out_ready) begin
        chk("sb_instr", instr, sb_q[0]);
        chk("sb_pmem_addr", pmem_addr, mon_addr);
        void'(sb_q.pop_front());
        mon_addr = mon_addr + 32'd4;
      end
      if (load_addr) mon_addr = load_val & 32'hFFFF_FFFC;
      rej = in_valid && er && req_bad;
      if (in_valid && er && !req_bad) sb_q.push_back(req_word);
      exp_sticky = rej || (exp_sticky && !err_clr);
      exp_pulse  = rej;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Drive one request and hold it until accepted (bounded wait)
  task automatic send(input int o, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im);
    logic [32:0] m;
    int k;
    m = model(o, d, s1, s2, im);
    req_bad = m[32]; req_word = m[31:0];
    op = 6'(o); rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      tick();
      @(negedge clk);
      k++;
    end
    chk("accept", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    in_valid = 0; op = 0; rd = 0; rs1 = 0; rs2 = 0; imm = 0;
    out_ready = 1; load_addr = 0; load_val = 0; err_clr = 0;
    rst_n = 1;
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pmem_addr", pmem_addr, 32'd0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_err_sticky", 32'(err_sticky), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1;
    tick(); tick();

    // ADDI then back-to-back SUB / BEQ
    send(10, 5'd1, 5'd0, 5'd0, 32'd5);
    chk("addi_word", instr, 32'h0050_0093);
    chk("addi_addr", pmem_addr, 32'd0);
    send(1, 5'd3, 5'd1, 5'd2, 32'd0);
    chk("sub_word", instr, 32'h4020_81B3);
    chk("sub_addr", pmem_addr, 32'd4);
    send(27, 5'd0, 5'd1, 5'd2, 32'd8);
    chk("beq_word", instr, 32'h0020_8463);
    chk("beq_addr", pmem_addr, 32'd8);
    tick();

    // JAL held under backpressure, then LUI
    out_ready = 0;
    send(33, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) begin
      chk("jal_hold_word", instr, 32'hFFDF_F0EF);
      chk("jal_hold_addr", pmem_addr, 32'd12);
      chk("jal_hold_rdy", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1;
    send(35, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
    chk("lui_word", instr, 32'h1234_52B7);
    chk("lui_addr", pmem_addr, 32'd16);
    tick(); tick();

    // Rejects: out of range, odd branch offset, illegal op
    send(10, 5'd1, 5'd1, 5'd0, 32'd2048);
    chk("rej_addi_pulse", 32'(err_pulse), 32'd1);
    chk("rej_addi_valid", 32'(out_valid), 32'd0);
    chk("rej_addi_addr", pmem_addr, 32'd20);
    send(27, 5'd0, 5'd1, 5'd2, 32'd3);
    chk("rej_beq_pulse", 32'(err_pulse), 32'd1);
    send(40, 5'd1, 5'd2, 5'd3, 32'd0);
    chk("rej_op_pulse", 32'(err_pulse), 32'd1);
    chk("rej_op_sticky", 32'(err_sticky), 32'd1);
    tick(); tick();
    chk("sticky_hold", 32'(err_sticky), 32'd1);
    err_clr = 1; tick(); err_clr = 0;
    chk("sticky_clr", 32'(err_sticky), 32'd0);
    err_clr = 1;
    send(16, 5'd1, 5'd1, 5'd0, 32'd32);
    err_clr = 0;
    chk("sticky_clr_vs_rej", 32'(err_sticky), 32'd1);
    err_clr = 1; tick(); err_clr = 0;
    send(12, 5'd7, 5'd8, 5'd0, 32'hFFFF_FFFF);
    chk("post_rej_addr", pmem_addr, 32'd20);
    tick(); tick();

    // Address reload and wrap
    load_addr = 1; load_val = 32'hFFFF_FFFE; tick(); load_addr = 0;
    send(21, 5'd4, 5'd2, 5'd0, 32'hFFFF_F800);
    chk("wrap_addr0", pmem_addr, 32'hFFFF_FFFC);
    send(26, 5'd0, 5'd2, 5'd4, 32'd2047);
    chk("wrap_addr1", pmem_addr, 32'd0);
    tick(); tick();

    // Randomised traffic with random output backpressure
    rand_mode = 1;
    for (int n = 0; n < 80; n++) begin
      send($urandom_range(0, 40), 5'($urandom), 5'($urandom), 5'($urandom),
           pick_imm($urandom_range(0, 18)));
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_mode = 0;
    out_ready = 1;
    tick(); tick(); tick();

    // Asynchronous reset while a word is held
    send(40, 5'd0, 5'd0, 5'd0, 32'd0);
    out_ready = 0;
    send(5, 5'd9, 5'd10, 5'd11, 32'd0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_instr", instr, 32'd0);
    chk("arst_pmem_addr", pmem_addr, 32'd0);
    chk("arst_err_pulse", 32'(err_pulse), 32'd0);
    chk("arst_err_sticky", 32'(err_sticky), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    #10 rst_n = 1;
    out_ready = 1;
    tick(); tick(); tick();
    send(0, 5'd1, 5'd2, 5'd3, 32'd0);
    chk("post_rst_word", instr, 32'h0031_00B3);
    chk("post_rst_addr", pmem_addr, 32'd0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port in_valid  input  1  request carries an operation.
REQ-004 SHALL have port in_ready  output  1  encoder accepts a request this cycle.
REQ-005 SHALL have port op  input  6  operation code: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 ADDI, 11 SLTI, 12 SLTIU, 13 XORI, 14 ORI, 15 ANDI, 16 SLLI, 17 SRLI, 18 SRAI, 19 LB, 20 LH, 21 LW, 22 LBU, 23 LHU, 24 SB, 25 SH, 26 SW, 27 BEQ, 28 BNE, 29 BLT, 30 BGE, 31 BLTU, 32 BGEU, 33 JAL, 34 JALR, 35 LUI, 36 AUIPC; 37-63 illegal.
REQ-006 SHALL have ports rd, rs1, rs2  input  5 each  register indices; unused fields ignored.
REQ-007 SHALL have port imm  input  32  immediate as a signed byte value (U-type: full 32-bit value).
REQ-008 SHALL have port out_valid  output  1  instr/pmem_addr hold a valid program-memory write.
REQ-009 SHALL have port out_ready  input  1  program-memory side accepts the write.
REQ-010 SHALL have ports instr  output  32  encoded RV32I word; pmem_addr  output  32  byte address of that word.
REQ-011 SHALL have ports load_addr  input  1  and load_val  input  32: reload the address counter.
REQ-012 SHALL have ports err_pulse  output  1  (one-cycle reject strobe) and err_sticky  output  1; err_clr  input  1.

Function
REQ-013 SHALL accept a request when in_valid && in_ready; in_ready = !out_valid || out_ready (single output register, full throughput).
REQ-014 SHALL register a legal request into instr/out_valid on the acceptance edge: latency 1 cycle, instr purely from op/rd/rs1/rs2/imm per RV32I base encoding.
REQ-015 SHALL hold instr, pmem_addr, out_valid stable while out_valid && !out_ready.
REQ-016 SHALL clear out_valid after an output handshake unless a new legal request is accepted on the same edge.
REQ-017 SHALL maintain a 32-bit address counter, reset 0, incremented by 4 on each output handshake, wrapping 0xFFFFFFFC -> 0x00000000; pmem_addr presents the counter value for the held word.
REQ-018 SHALL on load_addr set the counter to {load_val[31:2],2'b00}; load_addr SHALL win over a simultaneous increment; load_addr while out_valid SHALL also update the presented pmem_addr.
REQ-019 SHALL range-check imm: I/S-type imm in [-2048,2047]; SLLI/SRLI/SRAI imm in [0,31]; B-type in [-4096,4094] and even; JAL in [-1048576,1048574] and even; LUI/AUIPC imm[11:0]==0; R-type imm ignored.
REQ-020 SHALL treat illegal op or range violation as reject: request consumed (handshake completes), no output word, counter unchanged, err_pulse=1 next cycle, err_sticky set.
REQ-021 SHALL clear err_sticky on err_clr; simultaneous new reject and err_clr SHALL leave err_sticky=1.
REQ-022 SHALL assert in_ready during a reject cycle under the same rule as REQ-013; a held valid output stays held.

Reset
REQ-023 SHALL on rst_n=0 immediately force out_valid=0, instr=0, pmem_addr=0, counter=0, err_pulse=0, err_sticky=0; in_ready=1 after reset.
REQ-024 SHALL discard any held, un-handshaken word on reset mid-operation; no output before the first accepted request after rst_n rises.

Verification
REQ-025 SHALL cover: ADDI rd=1 rs1=0 imm=5, out_ready=1 -> instr=0x00500093, pmem_addr=0 one cycle later; next legal word at pmem_addr=4.
REQ-026 SHALL cover: SUB rd=3 rs1=1 rs2=2 then BEQ rs1=1 rs2=2 imm=8 back-to-back -> 0x402081B3 then 0x00208463, no bubble.
REQ-027 SHALL cover: JAL rd=1 imm=-4 -> 0xFFDFF0EF; LUI rd=5 imm=0x12345000 -> 0x123452B7; out_ready=0 for 3 cycles -> word and address stable, in_ready=0.
REQ-028 SHALL cover: ADDI imm=2048, BEQ imm=3, op=40 -> each err_pulse=1, no out_valid, counter unchanged, err_sticky=1 until err_clr.
REQ-029 SHALL cover: load_addr load_val=0xFFFFFFFE then two legal words -> pmem_addr 0xFFFFFFFC then 0x00000000.
REQ-030 SHALL cover: rst_n low asynchronously (mid-cycle) while out_valid=1 and out_ready=0 -> all outputs 0 at once, word dropped.
